// File: rtl/ysyx_22041752_divider.sv
// Multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the W variants.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve without iterating.
module ysyx_22041752_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic             div_word,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] dsr_mag;
  logic             neg_q;
  logic             neg_r;
  logic             word_q;

  // Extend a 32-bit word operand to full width, signed or unsigned.
  function automatic logic [WIDTH-1:0] ext32(input logic [31:0] x, input logic sgn);
    ext32 = {{(WIDTH-32){sgn & x[31]}}, x};
  endfunction

  // Word-op results are always the low 32 bits sign-extended.
  function automatic logic [WIDTH-1:0] fixw(input logic [WIDTH-1:0] v, input logic w);
    fixw = w ? {{(WIDTH-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operand preparation at acceptance time.
  logic [WIDTH-1:0] dvd_ext;
  logic [WIDTH-1:0] dvs_ext;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] min_val;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             is_zero;
  logic             is_ovf;

  always_comb begin
    dvd_ext = div_word ? ext32(dividend[31:0], div_signed) : dividend;
    dvs_ext = div_word ? ext32(divisor[31:0], div_signed) : divisor;
    dvd_neg = div_signed & dvd_ext[WIDTH-1];
    dvs_neg = div_signed & dvs_ext[WIDTH-1];
    dvd_mag = dvd_neg ? -dvd_ext : dvd_ext;
    dvs_mag = dvs_neg ? -dvs_ext : dvs_ext;
    min_val = div_word ? {{(WIDTH-31){1'b1}}, 31'b0} : {1'b1, {(WIDTH-1){1'b0}}};
    is_zero = (dvs_ext == '0);
    is_ovf  = div_signed & (dvd_ext == min_val) & (&dvs_ext);
  end

  // One restoring step: the carry-out of the WIDTH+1-bit subtract is the borrow.
  logic [WIDTH-1:0] shifted_lo;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_quo;

  always_comb begin
    shifted_lo = {part_rem[WIDTH-2:0], quo_acc[WIDTH-1]};
    trial      = {part_rem[WIDTH-1], shifted_lo} - {1'b0, dsr_mag};
    no_borrow  = ~trial[WIDTH];
    next_rem   = no_borrow ? trial[WIDTH-1:0] : shifted_lo;
    next_quo   = {quo_acc[WIDTH-2:0], no_borrow};
  end

  logic [WIDTH-1:0] q_signed;
  logic [WIDTH-1:0] r_signed;

  always_comb begin
    q_signed = neg_q ? -quo_acc : quo_acc;
    r_signed = neg_r ? -part_rem : part_rem;
  end

  assign div_ready = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: datapath registers are reset too, so results read 0 straight out of reset
  // and no X can leak from a half-finished operation into the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      part_rem  <= '0;
      quo_acc   <= '0;
      dsr_mag   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      word_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_valid) begin
            cnt    <= '0;
            word_q <= div_word;
            neg_q  <= dvd_neg ^ dvs_neg;
            neg_r  <= dvd_neg;
            if (is_zero) begin
              quotient  <= '1;
              remainder <= fixw(dvd_ext, div_word);
              state     <= DONE;
            end else if (is_ovf) begin
              quotient  <= dvd_ext;
              remainder <= '0;
              state     <= DONE;
            end else begin
              part_rem <= '0;
              quo_acc  <= dvd_mag;
              dsr_mag  <= dvs_mag;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          // After WIDTH steps, one more cycle applies signs and word extension.
          if (cnt == LAST_ITER) begin
            quotient  <= fixw(q_signed, word_q);
            remainder <= fixw(r_signed, word_q);
            state     <= DONE;
          end else begin
            part_rem <= next_rem;
            quo_acc  <= next_quo;
            cnt      <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_22041752_divider.md
YSYX_22041752_DIVIDER -- requirements
Module: ysyx_22041752_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving operand and result width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port flush, input, 1, synchronous abort of any in-flight or pending operation.
REQ-005 SHALL have port div_valid, input, 1, request strobe.
REQ-006 SHALL have port div_ready, output, 1, high when a request can be accepted.
REQ-007 SHALL have port div_signed, input, 1, 1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-008 SHALL have port div_word, input, 1, 1 = 32-bit word op (DIVW/DIVUW/REMW/REMUW).
REQ-009 SHALL have ports dividend and divisor, input, WIDTH each, operands.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have ports quotient and remainder, output, WIDTH each, results.

Function
REQ-013 SHALL implement the FSM IDLE -> CALC -> DONE -> IDLE.
REQ-014 SHALL drive div_ready = 1 only in IDLE; a request is accepted on a cycle where div_valid and div_ready are both 1.
REQ-015 SHALL latch the operands, div_signed and div_word on acceptance; input changes after acceptance have no effect.
REQ-016 SHALL, for word ops, sign-extend (signed) or zero-extend (unsigned) operand bits [31:0] to WIDTH before dividing.
REQ-017 SHALL, in CALC, perform one radix-2 restoring step per cycle on operand magnitudes: shift the partial remainder left, trial-subtract the divisor with a WIDTH+1-bit subtract, keep the difference and set the quotient bit when no borrow.
REQ-018 SHALL run exactly WIDTH iterations, tracked by a counter, then enter DONE.
REQ-019 SHALL, for signed ops, negate the quotient when the operand signs differ and give the remainder the sign of the dividend.
REQ-020 SHALL, for word ops, present bits [31:0] of each result sign-extended to WIDTH, for both signed and unsigned ops.
REQ-021 SHALL, on divide by zero, skip CALC and enter DONE the cycle after acceptance: quotient = all ones, remainder = extended dividend.
REQ-022 SHALL, on signed overflow (dividend = minimum negative value, divisor = -1, at the op width), skip CALC: quotient = dividend, remainder = 0.
REQ-023 SHALL assert out_valid only in DONE, hold quotient and remainder stable while out_valid = 1 and out_ready = 0, and return to IDLE on the cycle after out_valid and out_ready are both 1.
REQ-024 SHALL have a normal-path latency of WIDTH+1 cycles from the acceptance edge to out_valid (65 for WIDTH = 64).
REQ-025 SHALL, on flush = 1 in any state, enter IDLE on the next edge with out_valid = 0; flush SHALL take priority over acceptance in the same cycle, so no request is taken.

Reset
REQ-026 SHALL, on rst_n = 0 and without waiting for a clock, enter IDLE with out_valid = 0, quotient = 0, remainder = 0, iteration counter = 0.
REQ-027 SHALL abandon any in-flight operation on reset assertion mid-CALC; div_ready SHALL read 1 after release.

Verification
REQ-028 SHALL check unsigned 64-bit: 100 / 7 -> after 65 cycles quotient = 14, remainder = 2.
REQ-029 SHALL check signed: -7 / 2 -> quotient = -3 (0xFFFF_FFFF_FFFF_FFFD), remainder = -1.
REQ-030 SHALL check divide by zero: 5 / 0 -> out_valid one cycle after acceptance, quotient = 0xFFFF_FFFF_FFFF_FFFF, remainder = 5.
REQ-031 SHALL check word signed overflow: dividend[31:0] = 0x8000_0000, divisor[31:0] = 0xFFFF_FFFF -> quotient = 0xFFFF_FFFF_8000_0000, remainder = 0.
REQ-032 SHALL check backpressure: out_ready held 0 for 10 cycles after out_valid -> results stable, div_ready stays 0, IDLE one cycle after out_ready rises.
REQ-033 SHALL check flush mid-CALC at iteration 20 -> no out_valid, div_ready = 1 next cycle; a subsequent request returns the correct result.
